// File: rtl/branch_predict_resolve_if.sv
// Bus between the EX stage, the fetch PC-select logic and the branch resolver.
// Optional macro: BRANCH_STATS_EN adds the BR_COUNT / MISPRED_COUNT statistics outputs.
interface branch_predict_resolve_if #(
  parameter int XLEN = 32
);
  // fetch-side lookup
  logic [XLEN-1:0] PC_IF;
  logic            PREDICT_TAKEN_IF;

  // EX-side resolution inputs
  logic            EX_VALID;
  logic            STALL;
  logic [XLEN-1:0] PC_EX;
  logic [XLEN-1:0] Branch_imm;
  logic [XLEN-1:0] Alu_Jump_imm;
  logic [2:0]      func_3;
  logic            branch_signal;
  logic            jump_signal;
  logic            zero_signal;
  logic            sign_bit_signal;
  logic            sltu_bit_signal;
  logic            PRED_TAKEN_EX;

  // redirect back to IF/ID
  logic            FLUSH;
  logic [XLEN-1:0] REDIRECT_PC;

`ifdef BRANCH_STATS_EN
  logic [31:0]     BR_COUNT;
  logic [31:0]     MISPRED_COUNT;
`endif

  // pipeline side: drives fetch PC and EX operands, consumes prediction/redirect
  modport master (
    output PC_IF, EX_VALID, STALL, PC_EX, Branch_imm, Alu_Jump_imm, func_3,
           branch_signal, jump_signal, zero_signal, sign_bit_signal,
           sltu_bit_signal, PRED_TAKEN_EX,
`ifdef BRANCH_STATS_EN
    input  BR_COUNT, MISPRED_COUNT,
`endif
    input  PREDICT_TAKEN_IF, FLUSH, REDIRECT_PC
  );

  // resolver side
  modport slave (
    input  PC_IF, EX_VALID, STALL, PC_EX, Branch_imm, Alu_Jump_imm, func_3,
           branch_signal, jump_signal, zero_signal, sign_bit_signal,
           sltu_bit_signal, PRED_TAKEN_EX,
`ifdef BRANCH_STATS_EN
    output BR_COUNT, MISPRED_COUNT,
`endif
    output PREDICT_TAKEN_IF, FLUSH, REDIRECT_PC
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// Branch/jump resolver with a direct-mapped table of 2-bit saturating counters.
// Fetch reads the table combinationally; EX resolves against the carried
// prediction and issues a one-cycle registered FLUSH plus REDIRECT_PC.
// Optional macro: BRANCH_STATS_EN adds saturating branch / mispredict counters.
module branch_predict_resolve #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_LSB     = 2
) (
  input logic                  CLK,
  input logic                  RESET_N,
  branch_predict_resolve_if.slave bus
);

  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_WEAK_NT = 2'b01;
  localparam logic [1:0] CNT_MAX     = 2'b11;
  localparam logic [1:0] CNT_MIN     = 2'b00;

  logic [1:0]      bht [BHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;

  logic            flush_q;
  logic [XLEN-1:0] redirect_q;

  logic            resolve;
  logic            is_jump;
  logic            is_branch;
  logic            cond_valid;
  logic            actual_taken;
  logic            mispredict;
  logic            bht_update;
  logic [1:0]      cnt_cur;
  logic [1:0]      cnt_next;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] taken_target;
  logic [XLEN-1:0] fallthru_target;

  // PC bits outside the index field and the jump target LSB are intentionally ignored
  logic            unused_bits;
  assign unused_bits = ^{bus.PC_IF, bus.PC_EX, bus.Alu_Jump_imm[0]};

  assign lookup_idx = bus.PC_IF[IDX_LSB +: IDX_W];
  assign update_idx = bus.PC_EX[IDX_LSB +: IDX_W];

  // No bypass: a same-cycle update to this index becomes visible next cycle.
  assign bus.PREDICT_TAKEN_IF = bht[lookup_idx][1];

  // The instruction in EX during a FLUSH cycle is wrong-path and is dropped.
  assign resolve   = bus.EX_VALID & ~bus.STALL & ~flush_q;
  assign is_jump   = bus.jump_signal;
  assign is_branch = bus.branch_signal & ~bus.jump_signal;

  // decode branch condition from the ALU compare flags (rs1 - rs2)
  always_comb begin
    cond_valid   = 1'b1;
    actual_taken = 1'b0;
    case (bus.func_3)
      F3_BEQ:  actual_taken = bus.zero_signal;
      F3_BNE:  actual_taken = ~bus.zero_signal;
      F3_BLT:  actual_taken = bus.sign_bit_signal;
      F3_BGE:  actual_taken = ~bus.sign_bit_signal;
      F3_BLTU: actual_taken = bus.sltu_bit_signal;
      F3_BGEU: actual_taken = ~bus.sltu_bit_signal;
      default: begin
        cond_valid   = 1'b0;
        actual_taken = 1'b0;
      end
    endcase
  end

  assign jump_target     = {bus.Alu_Jump_imm[XLEN-1:1], 1'b0};
  assign taken_target    = bus.PC_EX + bus.Branch_imm;
  assign fallthru_target = bus.PC_EX + XLEN'(4);

  // Jumps have no target buffer behind them, so they always redirect.
  assign mispredict = resolve &
                      (is_jump | (is_branch & (actual_taken != bus.PRED_TAKEN_EX)));

  // select redirect target: jump wins over a branch flagged in the same cycle
  always_comb begin
    target = fallthru_target;
    if (is_jump) begin
      target = jump_target;
    end else if (actual_taken) begin
      target = taken_target;
    end
  end

  // register the redirect; FLUSH lasts exactly one cycle and reset drops it
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) begin
        redirect_q <= target;
      end
    end
  end

  assign bus.FLUSH       = flush_q;
  assign bus.REDIRECT_PC = redirect_q;

  // only well-formed conditional branches train the table
  assign bht_update = resolve & is_branch & cond_valid;
  assign cnt_cur    = bht[update_idx];

  // saturating counter step
  always_comb begin
    cnt_next = cnt_cur;
    if (actual_taken) begin
      if (cnt_cur != CNT_MAX) begin
        cnt_next = cnt_cur + 2'd1;
      end
    end else begin
      if (cnt_cur != CNT_MIN) begin
        cnt_next = cnt_cur - 2'd1;
      end
    end
  end

  // branch history table: reset to weakly not-taken, trained at resolution
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CNT_WEAK_NT;
      end
    end else if (bht_update) begin
      bht[update_idx] <= cnt_next;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] mispred_count_q;

  // saturating statistics: resolved branches/jumps and issued flushes
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (resolve && (is_jump || is_branch) && (br_count_q != 32'hFFFF_FFFF)) begin
        br_count_q <= br_count_q + 32'd1;
      end
      if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
        mispred_count_q <= mispred_count_q + 32'd1;
      end
    end
  end

  assign bus.BR_COUNT      = br_count_q;
  assign bus.MISPRED_COUNT = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve. Expected redirect results are
// queued when a resolution is driven and compared after the capturing edge.
module tb_branch_predict_resolve;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic        flush;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  branch_predict_resolve_if #(.XLEN(32)) bus_if ();

  branch_predict_resolve #(
    .XLEN(32),
    .BHT_ENTRIES(16),
    .IDX_LSB(2)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp_v);
    bus_if.PC_IF = pc;
    #1;
    chk(tag, {31'd0, bus_if.PREDICT_TAKEN_IF}, {31'd0, exp_v});
  endtask

  // queue the expectation, let one edge happen, then pop and compare
  task automatic cycle(input string tag, input logic fl, input logic [31:0] rd);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.flush = fl;
    e.rd = rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      chk({got.tag, "_flush"}, {31'd0, bus_if.FLUSH}, {31'd0, got.flush});
      chk({got.tag, "_redir"}, bus_if.REDIRECT_PC, got.rd);
    end
  endtask

  task automatic ex_idle();
    bus_if.EX_VALID      = 1'b0;
    bus_if.STALL         = 1'b0;
    bus_if.branch_signal = 1'b0;
    bus_if.jump_signal   = 1'b0;
    bus_if.PRED_TAKEN_EX = 1'b0;
  endtask

  task automatic ex_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic z, input logic s, input logic u, input logic pred);
    bus_if.EX_VALID        = 1'b1;
    bus_if.branch_signal   = 1'b1;
    bus_if.jump_signal     = 1'b0;
    bus_if.func_3          = f3;
    bus_if.PC_EX           = pc;
    bus_if.Branch_imm      = imm;
    bus_if.zero_signal     = z;
    bus_if.sign_bit_signal = s;
    bus_if.sltu_bit_signal = u;
    bus_if.PRED_TAKEN_EX   = pred;
  endtask

  task automatic ex_jmp(input logic [31:0] pc, input logic [31:0] jimm, input logic pred);
    bus_if.EX_VALID      = 1'b1;
    bus_if.branch_signal = 1'b0;
    bus_if.jump_signal   = 1'b1;
    bus_if.PC_EX         = pc;
    bus_if.Alu_Jump_imm  = jimm;
    bus_if.PRED_TAKEN_EX = pred;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus_if.PC_IF = 32'h0;
    bus_if.PC_EX = 32'h0;
    bus_if.Branch_imm = 32'h0;
    bus_if.Alu_Jump_imm = 32'h0;
    bus_if.func_3 = 3'b000;
    bus_if.zero_signal = 1'b0;
    bus_if.sign_bit_signal = 1'b0;
    bus_if.sltu_bit_signal = 1'b0;
    ex_idle();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_pred("rst_pred_40", 32'h40, 1'b0);
    chk("rst_flush", {31'd0, bus_if.FLUSH}, 32'd0);
    chk("rst_redir", bus_if.REDIRECT_PC, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // mispredicted taken beq, BHT[0] 01 -> 10
    ex_br(3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("beq_mis", 1'b1, 32'h120);
    ex_idle();
    cycle("beq_after", 1'b0, 32'h120);
    chk_pred("beq_pred_100", 32'h100, 1'b1);

    // mispredicted not-taken blt, BHT[0] 10 -> 01
    ex_br(3'b100, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("blt_mis", 1'b1, 32'h204);
    ex_idle();
    cycle("blt_after", 1'b0, 32'h204);
    chk_pred("blt_pred_100", 32'h100, 1'b0);

    // correctly predicted taken bne, BHT[0] 01 -> 10
    ex_br(3'b001, 32'h300, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("bne_ok", 1'b0, 32'h204);
    ex_idle();
    chk_pred("bne_pred_300", 32'h300, 1'b1);

    // JALR, bit 0 of target cleared, BHT[1] untouched
    ex_jmp(32'h44, 32'h3FF, 1'b1);
    cycle("jalr", 1'b1, 32'h3FE);
    ex_idle();
    cycle("jalr_after", 1'b0, 32'h3FE);
    chk_pred("jalr_pred_44", 32'h44, 1'b0);

    // branch and jump flagged together: jump target, no BHT training
    ex_br(3'b000, 32'h48, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.jump_signal  = 1'b1;
    bus_if.Alu_Jump_imm = 32'h500;
    cycle("br_jmp", 1'b1, 32'h500);
    ex_idle();
    cycle("br_jmp_after", 1'b0, 32'h500);
    chk_pred("br_jmp_pred_48", 32'h48, 1'b0);

    // saturation up at PC 0x10 (index 4): four taken, correctly predicted
    for (int i = 0; i < 4; i++) begin
      ex_br(3'b000, 32'h10, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle("sat_taken", 1'b0, 32'h500);
    end
    ex_idle();
    chk_pred("sat_hi_pred", 32'h10, 1'b1);
    // one not-taken from 11 must leave 10 (still taken)
    ex_br(3'b000, 32'h10, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("sat_nt1", 1'b1, 32'h14);
    ex_idle();
    cycle("sat_nt1_after", 1'b0, 32'h14);
    chk_pred("sat_after_nt1", 32'h10, 1'b1);
    // three more not-taken: 10 -> 01 -> 00 -> 00
    ex_br(3'b000, 32'h10, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("sat_nt2", 1'b0, 32'h14);
    ex_idle();
    chk_pred("sat_after_nt2", 32'h10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      ex_br(3'b000, 32'h10, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("sat_nt_lo", 1'b0, 32'h14);
    end
    // one taken from 00 gives 01: still not-taken
    ex_br(3'b000, 32'h10, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("sat_lo_taken", 1'b1, 32'h18);
    ex_idle();
    cycle("sat_lo_after", 1'b0, 32'h18);
    chk_pred("sat_lo_pred", 32'h10, 1'b0);

    // func_3=010: no flush, BHT[0] stays 10
    ex_br(3'b010, 32'h100, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("f3_010", 1'b0, 32'h18);
    ex_idle();
    chk_pred("f3_010_pred", 32'h100, 1'b1);

    // a valid EX instruction during the FLUSH cycle is ignored
    ex_br(3'b000, 32'h84, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("sq_first", 1'b1, 32'h94);
    ex_br(3'b000, 32'h84, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("sq_ignored", 1'b0, 32'h94);
    ex_idle();

    // stall blocks resolution and training
    ex_br(3'b000, 32'h88, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.STALL = 1'b1;
    cycle("stall_br", 1'b0, 32'h94);
    ex_idle();
    chk_pred("stall_pred_88", 32'h88, 1'b0);

    // FLUSH self-clears even when the following cycle stalls
    ex_jmp(32'h8C, 32'h700, 1'b0);
    cycle("stall_pre_jmp", 1'b1, 32'h700);
    ex_br(3'b000, 32'h88, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.STALL = 1'b1;
    cycle("stall_in_flush", 1'b0, 32'h700);
    ex_idle();

    // asynchronous reset while FLUSH is high
    ex_br(3'b000, 32'h8C, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("pre_reset", 1'b1, 32'h90);
    ex_idle();
    rst_n = 1'b0;
    #1;
    chk("async_rst_flush", {31'd0, bus_if.FLUSH}, 32'd0);
    chk("async_rst_redir", bus_if.REDIRECT_PC, 32'h0);
    chk_pred("async_rst_bht", 32'h100, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("stats_rst_br", bus_if.BR_COUNT, 32'd0);
    chk("stats_rst_mis", bus_if.MISPRED_COUNT, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // short mixed sequence after reset: 3 resolutions, 2 flushes
    ex_br(3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("post_beq", 1'b1, 32'h120);
    ex_idle();
    cycle("post_beq_after", 1'b0, 32'h120);
    ex_br(3'b001, 32'h104, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("post_bne_ok", 1'b0, 32'h120);
    ex_jmp(32'h108, 32'h801, 1'b0);
    cycle("post_jal", 1'b1, 32'h800);
    ex_idle();
    cycle("post_jal_after", 1'b0, 32'h800);
`ifdef BRANCH_STATS_EN
    chk("stats_br", bus_if.BR_COUNT, 32'd3);
    chk("stats_mis", bus_if.MISPRED_COUNT, 32'd2);
`endif

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
